// File: rtl/iir_meter_pkg.sv
// Shared types and width helpers for the IIR output meter.
// Purely declarative: no logic, no latency.
package iir_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_HOLD   = 2'd3
  } meter_state_e;

  // The counter spans the longer of the settle run and the window.
  function automatic int cnt_width(input int settle, input int win_log2);
    int win;
    int top;
    win = 1 << win_log2;
    top = (settle > win) ? settle : win;
    return $clog2(top + 1);
  endfunction

  // Sum of 2^win_log2 magnitudes, each below 2^w, fits in w+win_log2 bits.
  function automatic int sum_width(input int w, input int win_log2);
    return w + win_log2;
  endfunction

endpackage

// File: rtl/iir_meter_acc.sv
// Window statistics datapath: running max/min/peak/sum plus result registers.
// Results load on the same edge as the final update; no backpressure of its own.
module iir_meter_acc
  import iir_meter_pkg::*;
#(
  parameter int W        = 32,
  parameter int WIN_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic                    cap,
  input  logic [W-1:0]            x,
  output logic [W-1:0]            res_max,
  output logic [W-1:0]            res_min,
  output logic [W-1:0]            res_peak,
  output logic [W+WIN_LOG2-1:0]   res_sum
);

  localparam int SW = sum_width(W, WIN_LOG2);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]  abs_x;
  logic [W-1:0]  max_q, max_d;
  logic [W-1:0]  min_q, min_d;
  logic [W-1:0]  peak_q, peak_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  res_max_q, res_max_d;
  logic [W-1:0]  res_min_q, res_min_d;
  logic [W-1:0]  res_peak_q, res_peak_d;
  logic [SW-1:0] res_sum_q, res_sum_d;

  // Unsigned W-bit magnitude: the most negative input maps to 2^(W-1) exactly.
  always_comb begin
    abs_x = x[W-1] ? (~x + W'(1)) : x;
  end

  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    peak_d = peak_q;
    sum_d  = sum_q;
    if (clr) begin
      max_d  = MOST_NEG;
      min_d  = MOST_POS;
      peak_d = '0;
      sum_d  = '0;
    end else if (upd) begin
      if ($signed(x) > $signed(max_q)) max_d = x;
      if ($signed(x) < $signed(min_q)) min_d = x;
      if (abs_x > peak_q)              peak_d = abs_x;
      sum_d = sum_q + SW'(abs_x);
    end
  end

  always_comb begin
    res_max_d  = res_max_q;
    res_min_d  = res_min_q;
    res_peak_d = res_peak_q;
    res_sum_d  = res_sum_q;
    if (cap) begin
      res_max_d  = max_d;
      res_min_d  = min_d;
      res_peak_d = peak_d;
      res_sum_d  = sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q      <= '0;
      min_q      <= '0;
      peak_q     <= '0;
      sum_q      <= '0;
      res_max_q  <= '0;
      res_min_q  <= '0;
      res_peak_q <= '0;
      res_sum_q  <= '0;
    end else begin
      max_q      <= max_d;
      min_q      <= min_d;
      peak_q     <= peak_d;
      sum_q      <= sum_d;
      res_max_q  <= res_max_d;
      res_min_q  <= res_min_d;
      res_peak_q <= res_peak_d;
      res_sum_q  <= res_sum_d;
    end
  end

  assign res_max  = res_max_q;
  assign res_min  = res_min_q;
  assign res_peak = res_peak_q;
  assign res_sum  = res_sum_q;

endmodule

// File: rtl/iir_out_meter.sv
// Measurement sink: skips a settle run, then gathers max/min/peak/sum over a window.
// res_valid one cycle after the last window sample; results held until res_ready.
module iir_out_meter
  import iir_meter_pkg::*;
#(
  parameter int W        = 32,
  parameter int WIN_LOG2 = 10,
  parameter int SETTLE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [W-1:0]          res_max,
  output logic [W-1:0]          res_min,
  output logic [W-1:0]          res_peak,
  output logic [W+WIN_LOG2-1:0] res_sum
);

  localparam int CW = cnt_width(SETTLE, WIN_LOG2);
  localparam logic [CW-1:0] WIN_LAST    = CW'((1 << WIN_LOG2) - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  meter_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic          acc_clr, acc_upd, acc_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;
        end
      end
      ST_SETTLE: begin
        if (in_valid) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          if (cnt_q == WIN_LAST) begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // A start arriving with the handshake is deliberately dropped here.
        if (res_valid_q && res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_HOLD);
    acc_clr     = (state_q == ST_IDLE) && start;
    acc_upd     = (state_q == ST_ACCUM) && in_valid;
    acc_cap     = acc_upd && (cnt_q == WIN_LAST);
  end

  iir_meter_acc #(
    .W        (W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .upd      (acc_upd),
    .cap      (acc_cap),
    .x        (in_data),
    .res_max  (res_max),
    .res_min  (res_min),
    .res_peak (res_peak),
    .res_sum  (res_sum)
  );

  assign busy      = busy_q;
  assign res_valid = res_valid_q;

endmodule

// File: doc/iir_out_meter.md
# iir_out_meter

Measurement sink for the IIR filter cascade output stream. Consumes the signed 32-bit sample stream from the last biquad section and discards a programmable settling run of samples. It then measures one window of 2^WIN_LOG2 samples: max, min, peak magnitude and sum of magnitudes. The results are presented on a valid/ready handshake to the control/readout logic, which uses them for in-system filter response checks.

## Interface
- W, 32, sample width (signed two's complement)
- WIN_LOG2, 10, log2 of measurement window length in samples (≥1)
- SETTLE, 16, samples discarded after start before the window opens (0 allowed)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample qualifier; one sample per cycle when high
- in_data  in  W  signed filter output sample
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE
- busy  out  1  high in SETTLE, ACCUM, HOLD
- res_valid  out  1  result registers valid
- res_ready  in  1  consumer accepts result
- res_max  out  W  signed maximum of window
- res_min  out  W  signed minimum of window
- res_peak  out  W  unsigned max |sample| of window
- res_sum  out  W+WIN_LOG2  unsigned sum of |sample| over window

## Operation
- States: IDLE, SETTLE, ACCUM, HOLD.
- IDLE:
  - start → SETTLE if SETTLE>0, else ACCUM.
  - On that start edge, the sample counter is cleared, and so are the accumulators: max = most negative, min = most positive, peak = 0, sum = 0.
  - in_valid samples are ignored.
- SETTLE:
  - Each in_valid sample increments the counter and is discarded.
  - The SETTLE-th sample → ACCUM with the counter cleared.
- ACCUM: each in_valid sample updates max, min, peak (|x|) and sum (|x|), and increments the counter. The 2^WIN_LOG2-th sample is included, then → HOLD.
- HOLD:
  - res_valid=1 and all res_* stable.
  - in_valid samples and start are ignored.
  - res_valid && res_ready → IDLE.
- Cycles without in_valid never advance the counter (bubbles tolerated in every state).
- Arithmetic:
  - |x| is computed in W-bit unsigned, so |−2^(W−1)| = 2^(W−1) exactly, with no saturation.
  - res_sum is W+WIN_LOG2 bits wide and cannot overflow.
  - max/min are signed compares.
- start while busy: ignored, no restart.
- rst at any time: state → IDLE, all outputs 0, any in-progress measurement aborted without producing a result.

## Timing
- Reset values: busy=0, res_valid=0, res_max=res_min=res_peak=res_sum=0.
- All outputs are registered.
- busy rises the cycle after start is sampled in IDLE.
- res_valid rises the cycle after the edge that captures the final window sample. res_* update on that same edge.
- Handshake:
  - Transfer occurs on the edge where res_valid && res_ready.
  - res_valid and busy are 0 the following cycle.
  - A new start is accepted from that cycle onward.
  - res_ready high before res_valid has no effect.
- start and handshake in the same HOLD cycle: the handshake completes and start is dropped.
- Minimum measurement: SETTLE + 2^WIN_LOG2 valid samples, plus 1 cycle to res_valid.

## Structure
- Package iir_meter_pkg holds:
  - the state enum (IDLE, SETTLE, ACCUM, HOLD);
  - a function for the counter width, ceil(log2(max(SETTLE, 2^WIN_LOG2)+1));
  - the sum-width derivation helper.
- One sub-module, iir_meter_acc: the max/min/peak/sum datapath with clear and update strobes.
- The FSM and counter live in iir_out_meter.

## Test plan
1. Reset: hold rst 3 cycles with random inputs → busy=0, res_valid=0, all res_* = 0.
2. WIN_LOG2=2, SETTLE=2: pulse start, then feed 100, 200, 5, −7, 3, −1 back-to-back → 100 and 200 ignored; res_max=5, res_min=−7, res_peak=7, res_sum=16; res_valid high exactly one cycle after −1 is sampled.
3. Same config, samples with bubbles (in_valid pattern 1,0,0,1,…) → identical results to scenario 2; res_valid timing tracks the last valid sample only.
4. Backpressure: hold res_ready=0 for 10 cycles, feeding samples and start pulses meanwhile → res_* stable, no restart. Raise res_ready → res_valid and busy are 0 next cycle; a start the following cycle is accepted.
5. Extremes, W=32, WIN_LOG2=2, SETTLE=0: four samples of −2^31 → res_max=res_min=−2^31, res_peak=2^31, res_sum=2^33. Repeat with four samples of 2^31−1 → res_sum=2^33−4.
6. Abort: rst asserted after 2 ACCUM samples → IDLE, no res_valid. A fresh start with scenario 2 stimulus then yields scenario 2 results exactly.
